// File: rtl/lsu_rmw.sv
// ---------------------------------------------------------------------------
// lsu_rmw -- load/store unit sitting between the ALU/control path and a
// word-wide Data_Memory.
//
// Purpose:
//   * Presents word-aligned accesses to memory (mem_addr = address & ~3).
//   * Loads are combinational: byte/halfword lane select with sign or zero
//     extension (LB, LH, LW, LBU, LHU).
//   * SW writes the full word in one cycle.
//   * SB/SH use a two-cycle read-modify-write: cycle 1 reads the word and
//     stalls the core, cycle 2 writes the merged word back.
//   * Misaligned, out-of-range, illegal-funct3 and read+write requests are
//     suppressed (no strobes, load_data = 0) and flagged on `fault`.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   MemRead, MemWrite   load / store request from the control unit
//   funct3              RV32I load/store size and signedness
//   address             byte address from the ALU
//   write_data          store data (rs2)
//   mem_rdata           combinational read data for mem_addr
//   mem_read, mem_write memory strobes
//   mem_addr, mem_wdata word address and full write word
//   load_data           extended load result
//   stall               core must hold PC and inputs this cycle
//   fault               request suppressed this cycle
//   rmw_count           completed RMW stores (saturating)
//   fault_count         faulted requests (saturating)
//
// Configuration:
//   LSU_STATS_EN        define to build the two statistics counters; when
//                       undefined the counter ports are tied to zero.
// ---------------------------------------------------------------------------
module lsu_rmw #(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [2:0]       funct3,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    input  logic [31:0]      mem_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [31:0]      load_data,
    output logic             stall,
    output logic             fault,
    output logic [CNT_W-1:0] rmw_count,
    output logic [CNT_W-1:0] fault_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] cap_word_q;   // word read during the RMW read cycle
    logic [1:0]  cap_lane_q;   // address[1:0] of the sub-word store
    logic        cap_half_q;   // 1 = SH, 0 = SB
    logic [15:0] cap_data_q;   // write_data[15:0]
    logic [31:0] cap_addr_q;   // word address to write back

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE; RMW_WR ignores inputs)
    // ------------------------------------------------------------------
    logic is_idle;
    logic is_half;
    logic is_word;
    logic load_ok;
    logic store_ok;
    logic misalign;
    logic out_of_range;
    logic req_bad;
    logic req_ok;
    logic go_load;
    logic go_sw;
    logic go_rmw;

    always_comb begin
        is_idle      = (state_q == ST_IDLE);
        is_half      = (funct3[1:0] == 2'b01);
        is_word      = (funct3[1:0] == 2'b10);
        load_ok      = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        store_ok     = (funct3 inside {3'b000, 3'b001, 3'b010});
        misalign     = (is_half && address[0]) || (is_word && (address[1:0] != 2'b00));
        out_of_range = (address >= 32'(MEM_BYTES));
        req_bad      = (MemRead && MemWrite)
                    || (MemRead && !load_ok)
                    || (MemWrite && !store_ok)
                    || misalign
                    || out_of_range;
        req_ok       = is_idle && (MemRead || MemWrite) && !req_bad;
        go_load      = req_ok && MemRead;
        go_sw        = req_ok && MemWrite && is_word;
        go_rmw       = req_ok && MemWrite && !is_word;
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension
    // ------------------------------------------------------------------
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    // NOTE: every combinational output gets a default before the case so
    // that no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        lane_half = address[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (address[1:0])
            2'b00:   lane_byte = mem_rdata[7:0];
            2'b01:   lane_byte = mem_rdata[15:8];
            2'b10:   lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        load_ext = '0;
        case (funct3)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b010:  load_ext = mem_rdata;
            3'b100:  load_ext = {24'd0, lane_byte};
            3'b101:  load_ext = {16'd0, lane_half};
            default: load_ext = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // RMW merge: replace the captured byte/halfword in the captured word
    // ------------------------------------------------------------------
    logic [31:0] merged_word;

    always_comb begin
        merged_word = cap_word_q;
        if (cap_half_q) begin
            if (cap_lane_q[1]) merged_word[31:16] = cap_data_q;
            else               merged_word[15:0]  = cap_data_q;
        end else begin
            unique case (cap_lane_q)
                2'b00:   merged_word[7:0]   = cap_data_q[7:0];
                2'b01:   merged_word[15:8]  = cap_data_q[7:0];
                2'b10:   merged_word[23:16] = cap_data_q[7:0];
                default: merged_word[31:24] = cap_data_q[7:0];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. mem_write in RMW_WR comes straight from state_q, so an
    // asynchronous reset drops it immediately and no partial write occurs.
    // ------------------------------------------------------------------
    always_comb begin
        fault     = is_idle && (MemRead || MemWrite) && req_bad;
        mem_read  = go_load || go_rmw;
        stall     = go_rmw;
        load_data = go_load ? load_ext : 32'd0;
        if (is_idle) begin
            mem_write = go_sw;
            mem_addr  = (MemRead || MemWrite) ? {address[31:2], 2'b00} : 32'd0;
            mem_wdata = go_sw ? write_data : 32'd0;
        end else begin
            mem_write = 1'b1;
            mem_addr  = cap_addr_q;
            mem_wdata = merged_word;
        end
    end

    // ------------------------------------------------------------------
    // FSM and capture registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the capture registers are plain data but are reset
            // anyway so the merged word is deterministic from power-up.
            state_q    <= ST_IDLE;
            cap_word_q <= '0;
            cap_lane_q <= '0;
            cap_half_q <= 1'b0;
            cap_data_q <= '0;
            cap_addr_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go_rmw) begin
                        state_q    <= ST_RMW_WR;
                        cap_word_q <= mem_rdata;
                        cap_lane_q <= address[1:0];
                        cap_half_q <= is_half;
                        cap_data_q <= write_data[15:0];
                        cap_addr_q <= {address[31:2], 2'b00};
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
`ifdef LSU_STATS_EN
    logic [CNT_W-1:0] rmw_cnt_q;
    logic [CNT_W-1:0] fault_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rmw_cnt_q   <= '0;
            fault_cnt_q <= '0;
        end else begin
            if ((state_q == ST_RMW_WR) && !(&rmw_cnt_q))
                rmw_cnt_q <= rmw_cnt_q + 1'b1;
            if (fault && !(&fault_cnt_q))
                fault_cnt_q <= fault_cnt_q + 1'b1;
        end
    end

    assign rmw_count   = rmw_cnt_q;
    assign fault_count = fault_cnt_q;
`else
    assign rmw_count   = '0;
    assign fault_count = '0;
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// ---------------------------------------------------------------------------
// tb_lsu_rmw -- directed bench for lsu_rmw with a small word-wide data
// memory attached. Inputs change 1 ns after the rising edge; outputs are
// examined at the falling edge; memory writes commit on the rising edge.
// ---------------------------------------------------------------------------
module tb_lsu_rmw;

    localparam int unsigned MEM_BYTES = 256;
    localparam int unsigned CNT_W     = 16;

    logic             clk;
    logic             rst;
    logic             MemRead;
    logic             MemWrite;
    logic [2:0]       funct3;
    logic [31:0]      address;
    logic [31:0]      write_data;
    logic [31:0]      mem_rdata;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      load_data;
    logic             stall;
    logic             fault;
    logic [CNT_W-1:0] rmw_count;
    logic [CNT_W-1:0] fault_count;

    int total;
    int bad;

    logic [31:0] mem [0:63];

    lsu_rmw #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .funct3      (funct3),
        .address     (address),
        .write_data  (write_data),
        .mem_rdata   (mem_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .load_data   (load_data),
        .stall       (stall),
        .fault       (fault),
        .rmw_count   (rmw_count),
        .fault_count (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        address    = addr;
        write_data = wd;
    endtask

    // Advance to the falling edge of the current cycle.
    task automatic to_sample();
        @(negedge clk);
    endtask

    // Finish the current cycle and move 1 ns past the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One load: check strobes and result, then step.
    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, addr, 32'd0);
        to_sample();
        check({tag, ".data"},  load_data, exp);
        check({tag, ".rd"},    mem_read, 1'b1);
        check({tag, ".stall"}, stall, 1'b0);
        check({tag, ".fault"}, fault, 1'b0);
        next_cycle();
    endtask

    // One faulting request: no strobes, zero load data, fault high.
    task automatic do_fault(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
        drive(rd, wr, f3, addr, 32'hDEAD_BEEF);
        to_sample();
        check({tag, ".fault"}, fault, 1'b1);
        check({tag, ".rd"},    mem_read, 1'b0);
        check({tag, ".wr"},    mem_write, 1'b0);
        check({tag, ".data"},  load_data, 32'd0);
        check({tag, ".stall"}, stall, 1'b0);
        next_cycle();
    endtask

    // Sub-word store: two cycles, stall only in the first.
    task automatic do_rmw(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_word);
        drive(1'b0, 1'b1, f3, addr, wd);
        to_sample();
        check({tag, ".c1.stall"}, stall, 1'b1);
        check({tag, ".c1.rd"},    mem_read, 1'b1);
        check({tag, ".c1.wr"},    mem_write, 1'b0);
        next_cycle();
        to_sample();
        check({tag, ".c2.stall"}, stall, 1'b0);
        check({tag, ".c2.wr"},    mem_write, 1'b1);
        check({tag, ".c2.rd"},    mem_read, 1'b0);
        check({tag, ".c2.addr"},  mem_addr, {addr[31:2], 2'b00});
        check({tag, ".c2.wdata"}, mem_wdata, exp_word);
        next_cycle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4] = 32'hCAFE_F00D;
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

        // Reset state with no request
        repeat (2) @(posedge clk);
        to_sample();
        check("rst.rd",    mem_read, 1'b0);
        check("rst.wr",    mem_write, 1'b0);
        check("rst.stall", stall, 1'b0);
        check("rst.fault", fault, 1'b0);
        check("rst.data",  load_data, 32'd0);
        check("rst.rmw",   32'(rmw_count), 32'd0);
        check("rst.fcnt",  32'(fault_count), 32'd0);
        rst = 1'b1;
        next_cycle();

        // SW 0x08, then LW 0x08
        drive(1'b0, 1'b1, 3'b010, 32'h08, 32'h1122_3344);
        to_sample();
        check("sw.wr",    mem_write, 1'b1);
        check("sw.rd",    mem_read, 1'b0);
        check("sw.addr",  mem_addr, 32'h08);
        check("sw.wdata", mem_wdata, 32'h1122_3344);
        check("sw.stall", stall, 1'b0);
        next_cycle();
        do_load("lw08", 3'b010, 32'h08, 32'h1122_3344);

        // SB 0x09 then byte loads
        do_rmw("sb09", 3'b000, 32'h09, 32'h0000_00AA, 32'h1122_AA44);
        do_load("lb09",  3'b000, 32'h09, 32'hFFFF_FFAA);
        do_load("lbu09", 3'b100, 32'h09, 32'h0000_00AA);

        // SH 0x0A then halfword loads
        do_rmw("sh0a", 3'b001, 32'h0A, 32'h0000_BEEF, 32'hBEEF_AA44);
        do_load("lw08b", 3'b010, 32'h08, 32'hBEEF_AA44);
        do_load("lh0a",  3'b001, 32'h0A, 32'hFFFF_BEEF);
        do_load("lhu0a", 3'b101, 32'h0A, 32'h0000_BEEF);
        do_load("lbu08", 3'b100, 32'h08, 32'h0000_0044);

        // Faults: misaligned word, misaligned half, out of range, both requests
        do_fault("lw06",  1'b1, 1'b0, 3'b010, 32'h06);
        do_fault("sh0b",  1'b0, 1'b1, 3'b001, 32'h0B);
        do_fault("lw100", 1'b1, 1'b0, 3'b010, 32'h100);
        do_fault("rdwr",  1'b1, 1'b1, 3'b010, 32'h08);
        check("mem08.kept", mem[2], 32'hBEEF_AA44);
        check("mem00.kept", mem[0], 32'h0000_0000);

        // Idle cycle: counters and zero outputs
        drive(1'b0, 1'b0, 3'b010, 32'h08, 32'h0);
        to_sample();
        check("idle.rd",   mem_read, 1'b0);
        check("idle.wr",   mem_write, 1'b0);
        check("idle.data", load_data, 32'd0);
        check("idle.fault", fault, 1'b0);
`ifdef LSU_STATS_EN
        check("cnt.rmw",   32'(rmw_count), 32'd2);
        check("cnt.fault", 32'(fault_count), 32'd4);
`else
        check("cnt.rmw",   32'(rmw_count), 32'd0);
        check("cnt.fault", 32'(fault_count), 32'd0);
`endif
        next_cycle();

        // Illegal funct3 for load and store
        do_fault("ld011", 1'b1, 1'b0, 3'b011, 32'h08);
        do_fault("st100", 1'b0, 1'b1, 3'b100, 32'h08);
        check("mem08.kept2", mem[2], 32'hBEEF_AA44);

        // SB 0x10 with reset pulsed during RMW_WR
        drive(1'b0, 1'b1, 3'b000, 32'h10, 32'h0000_0055);
        to_sample();
        check("abort.c1.stall", stall, 1'b1);
        next_cycle();
        to_sample();
        check("abort.c2.wr", mem_write, 1'b1);
        rst = 1'b0;
        #1;
        check("abort.wr.drop", mem_write, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        next_cycle();
        to_sample();
        rst = 1'b1;
        next_cycle();
        check("abort.mem10", mem[4], 32'hCAFE_F00D);
        do_load("lw10", 3'b010, 32'h10, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit between the ALU/control path and the word-wide `Data_Memory`. Presents word-aligned accesses to memory and performs byte/halfword lane selection with sign/zero extension on loads. Sub-word stores (SB/SH) use a two-cycle read-modify-write sequence that stalls the core for one cycle. Misaligned, out-of-range and illegal accesses are suppressed and flagged.

## Interface

- `MEM_BYTES`, 256: size of the data space in bytes; byte addresses `>= MEM_BYTES` fault.
- `CNT_W`, 16: width of the statistics counters.

- `clk` in 1: clock; memory writes commit on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `MemRead` in 1: load request from the Control Unit.
- `MemWrite` in 1: store request from the Control Unit.
- `funct3` in 3: access size and signedness (RV32I load/store encoding).
- `address` in 32: byte address from the ALU result.
- `write_data` in 32: store data (rs2).
- `mem_rdata` in 32: `Data_Memory` read_data; combinational for `mem_addr`.
- `mem_read` out 1: to `Data_Memory` MemRead.
- `mem_write` out 1: to `Data_Memory` MemWrite.
- `mem_addr` out 32: word-aligned address (`address & ~3`).
- `mem_wdata` out 32: full word to write.
- `load_data` out 32: extended load result to writeback.
- `stall` out 1: core must hold the PC and all inputs this cycle.
- `fault` out 1: access suppressed (misaligned, out of range, illegal funct3, or both requests set).
- `rmw_count` out CNT_W: number of completed RMW stores.
- `fault_count` out CNT_W: number of faulted requests.

## Operation

- Little-endian lanes: the byte lane is `address[1:0]`; the halfword lane is `address[1]`.
- Loads (combinational, state IDLE): LB=000 and LH=001 sign-extend; LW=010 passes the word; LBU=100 and LHU=101 zero-extend. Other funct3 values fault.
- Stores: SW=010 completes in one cycle, with `mem_write`=1 and `mem_wdata`=`write_data`. SB=000 and SH=001 use RMW. Other funct3 values fault.
- Faults:
  - Halfword access with `address[0]`=1.
  - Word access with `address[1:0]`≠0.
  - `address >= MEM_BYTES`.
  - `MemRead && MemWrite` both set.
  - Illegal funct3.
  - On any fault: `mem_read`, `mem_write` and `load_data` are 0 and `fault`=1 for that cycle; no memory state changes.
- FSM states:
  - IDLE → RMW_WR on a legal SB/SH. In that cycle: `mem_read`=1, `stall`=1. At the clock edge, capture `mem_rdata`, the lane, `write_data[15:0]` and `mem_addr`.
  - RMW_WR → IDLE unconditionally. In that cycle: `mem_write`=1, `stall`=0, and `mem_wdata` is the captured word with the addressed byte or halfword replaced. Inputs are ignored.
- Counters saturate at all-ones.
  - `rmw_count` increments on the RMW_WR → IDLE transition.
  - `fault_count` increments on every edge where `fault`=1.

## Timing

- Reset values: state IDLE; capture registers 0; counters 0. All outputs are driven combinationally from IDLE with inputs, so no request gives all-zero outputs.
- Load latency is 0 cycles (same-cycle `load_data`). SW latency is 1 edge.
- SB/SH take 2 cycles: `stall` is high in cycle 1 only, and the write commits at the end of cycle 2.
- Reset asserted during RMW_WR: the FSM returns to IDLE asynchronously, `mem_write` drops immediately, and no partial write occurs.
- No request (`MemRead`=`MemWrite`=0): `mem_read`=`mem_write`=0 and `load_data`=0.

## Configuration

- `LSU_STATS_EN` defined: `rmw_count` and `fault_count` are implemented as described.
- `LSU_STATS_EN` undefined: no counter flops are built; both ports remain and are tied to 0.

## Test plan

- Reset, then SW 0x08 with data 0x11223344, then LW 0x08: `load_data`=0x11223344, `stall` never set.
- SB 0x09 with data 0x000000AA: `stall`=1 for exactly one cycle, then `mem_write`=1 with `mem_wdata`=0x1122AA44. A following LB 0x09 returns 0xFFFFFFAA; LBU 0x09 returns 0x000000AA.
- SH 0x0A with data 0x0000BEEF: the word at 0x08 becomes 0xBEEFAA44. LH 0x0A returns 0xFFFFBEEF; LHU 0x0A returns 0x0000BEEF.
- LW 0x06, SH 0x0B, LW 0x100 (MEM_BYTES=256), and `MemRead`=`MemWrite`=1: each gives `fault`=1, no memory strobe, and memory unchanged.
- SB 0x10 with reset pulsed low during the RMW_WR cycle: `mem_write` falls asynchronously and the word at 0x10 is unchanged.
- With `LSU_STATS_EN`, after the sequence above: `rmw_count`=2 and `fault_count`=4. Without the macro, both read 0.
